cfb_stream_enc: RTL and testbench



---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_round_unit.sv | 38 +++
 rtl/cfb_stream_enc.sv | 109 ++++++++++
 tb/tb_cfb_stream_enc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and byte/word helpers for the
// iterative CFB stream engine.
package aes_pkg;
    localparam int NR = 10;
    localparam int BW = 128;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_KS, S_OUT} enc_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are top row first; each output row is the GF(2^8) product with {02 03 01 01} rotated.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction
endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES-128 round: SubBytes, ShiftRows, optional MixColumns and
// AddRoundKey, with the round key for round rnd expanded on the fly from rk_in.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [BW-1:0] state_in,
    input  logic [BW-1:0] rk_in,
    input  logic [3:0]    rnd,
    input  logic          last_round,
    output logic [BW-1:0] state_out,
    output logic [BW-1:0] rk_out
);
    logic [7:0]    sb [16];
    logic [BW-1:0] shifted;
    logic [BW-1:0] mixed;
    logic [31:0]   tmp, w0, w1, w2, w3;

    always_comb begin
        for (int i = 0; i < 16; i++)
            sb[i] = SBOX[state_in[BW-1-8*i -: 8]];
        // Byte i sits at row i%4 of column i/4; row r rotates left by r columns.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[BW-1-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            mixed[BW-1-32*c -: 32] = last_round ? shifted[BW-1-32*c -: 32]
                                                : mix_column(shifted[BW-1-32*c -: 32]);
    end

    assign tmp = sub_word(rot_word(rk_in[31:0])) ^ {RCON[rnd], 24'h0};
    assign w0  = rk_in[127:96] ^ tmp;
    assign w1  = rk_in[95:64]  ^ w0;
    assign w2  = rk_in[63:32]  ^ w1;
    assign w3  = rk_in[31:0]   ^ w2;

    assign rk_out    = {w0, w1, w2, w3};
    assign state_out = mixed ^ rk_out;
endmodule

// File: rtl/cfb_stream_enc.sv
// AES-128 CFB-128 stream encryptor: the keystream for the next block is
// computed one round per clock while waiting, then XORed in the handshake cycle.
module cfb_stream_enc
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] key,
    input  logic [BW-1:0] iv,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    enc_state_t    state, state_nx;
    logic [BW-1:0] key_r, fb, st, rk, ks;
    logic [BW-1:0] ru_state, ru_rk;
    logic [3:0]    rnd;
    logic          last_round;

    assign last_round = (rnd == 4'(NR));

    aes_round_unit u_round (
        .state_in   (st),
        .rk_in      (rk),
        .rnd        (rnd),
        .last_round (last_round),
        .state_out  (ru_state),
        .rk_out     (ru_rk)
    );

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD:  state_nx = S_ROUND;
            S_ROUND: if (last_round) state_nx = S_KS;
            S_KS: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = out_last ? S_IDLE : S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: key, feedback and keystream are cleared as well, so an abandoned stream leaves nothing behind.
            key_r    <= '0;
            fb       <= '0;
            st       <= '0;
            rk       <= '0;
            ks       <= '0;
            rnd      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    key_r <= key;
                    fb    <= iv;
                end
                S_LOAD: begin
                    st  <= fb ^ key_r;
                    rk  <= key_r;
                    rnd <= 4'd1;
                end
                S_ROUND: begin
                    if (last_round) begin
                        ks <= ru_state;
                    end else begin
                        st  <= ru_state;
                        rk  <= ru_rk;
                        rnd <= rnd + 4'd1;
                    end
                end
                S_KS: if (in_valid) begin
                    out_data <= in_data ^ ks;
                    out_last <= in_last;
                    fb       <= in_data ^ ks;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfb_stream_enc.sv
// Self-checking bench for cfb_stream_enc: NIST CFB-128 vectors, latency,
// backpressure, reset and start-while-busy, plus random streams against a byte-level AES model.
module tb_cfb_stream_enc;
    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, in_last;
    logic          out_valid, out_ready, out_last, busy;
    logic [127:0]  key, iv, in_data, out_data;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [7:0]    sb [256];
    logic [127:0]  pt_q [4];
    logic [127:0]  ct_q [4];

    localparam logic [127:0] K_NIST  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_NIST = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] C1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] C2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
    localparam logic [127:0] C3 = 128'h26751f67a3cbb140b1808cf187a4f4df;
    localparam logic [127:0] C4 = 128'hc04b05357c5d1c0eeac4c66f9ff7f2e6;

    always #5 clk = ~clk;

    cfb_stream_enc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: plain GF(2^8) arithmetic on byte arrays
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box from the multiplicative inverse followed by the affine transform.
    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  tw;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4)+(i%4))%4)+(i%4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver
    // Counts clock cycles until in_ready is seen (bounded); caller has already raised start/out_ready.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); @(negedge clk);
            start = 1'b0; out_ready = 1'b0;
            cyc++;
        end while (!in_ready && cyc < 200);
    endtask

    task automatic run_stream(input logic [127:0] k, input logic [127:0] v, input int nblk,
                              input int st_in, input int st_out, input bit poke, input int abort_at);
        logic [127:0] fb, exp, held;
        logic         last;
        int           lat;
        fb = v;
        key = k; iv = v; start = 1'b1;
        wait_ready(lat);
        check("start_to_ready", 128'(lat), 128'd12);
        for (int b = 0; b < nblk; b++) begin
            last = (b == nblk - 1);
            exp  = pt_q[b] ^ aes_ref(k, fb);
            fb   = exp;
            for (int s = 0; s < st_in; s++) begin
                if (poke && s == 0) begin
                    start = 1'b1; key = ~k; iv = ~v;
                end
                @(posedge clk); @(negedge clk);
                start = 1'b0;
                check("ready_held_in_ks", 128'(in_ready), 128'd1);
            end
            in_valid = 1'b1; in_data = pt_q[b]; in_last = last;
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0; in_data = rand128(); in_last = 1'b0;
            check("in_to_out_valid", 128'(out_valid), 128'd1);
            held = out_data;
            for (int s = 0; s < st_out; s++) begin
                @(posedge clk); @(negedge clk);
                check("out_data_stable", out_data, held);
                check("ready_low_in_out", 128'(in_ready), 128'd0);
            end
            check("ciphertext", out_data, exp);
            check("out_last", 128'(out_last), 128'(last));
            ct_q[b] = out_data;
            out_ready = 1'b1;
            if (last) begin
                @(posedge clk); @(negedge clk);
                out_ready = 1'b0;
                check("idle_busy", 128'(busy), 128'd0);
                check("idle_out_valid", 128'(out_valid), 128'd0);
            end else if (b == abort_at) begin
                @(posedge clk); @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                check("rst_in_ready", 128'(in_ready), 128'd0);
                check("rst_out_valid", 128'(out_valid), 128'd0);
                check("rst_out_data", out_data, 128'd0);
                check("rst_out_last", 128'(out_last), 128'd0);
                check("rst_busy", 128'(busy), 128'd0);
                rst = 1'b0;
                return;
            end else begin
                wait_ready(lat);
                check("out_to_ready", 128'(lat), 128'd12);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, si, so;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        key = '0; iv = '0; in_data = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'd0);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out_data", out_data, 128'd0);
        check("reset_out_last", 128'(out_last), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        pt_q[0] = P1;
        run_stream(K_NIST, IV_NIST, 1, 0, 0, 1'b0, -1);
        check("kat_single_c1", ct_q[0], C1);

        pt_q[0] = P1; pt_q[1] = P2; pt_q[2] = P3; pt_q[3] = P4;
        run_stream(K_NIST, IV_NIST, 4, 0, 0, 1'b0, -1);
        check("kat_c1", ct_q[0], C1);
        check("kat_c2", ct_q[1], C2);
        check("kat_c3", ct_q[2], C3);
        check("kat_c4", ct_q[3], C4);

        run_stream(K_NIST, IV_NIST, 4, 15, 20, 1'b0, -1);
        check("stall_c1", ct_q[0], C1);
        check("stall_c4", ct_q[3], C4);

        run_stream(K_NIST, IV_NIST, 4, 3, 2, 1'b1, -1);
        check("poke_c2", ct_q[1], C2);
        check("poke_c4", ct_q[3], C4);

        run_stream(K_NIST, IV_NIST, 4, 0, 0, 1'b0, 0);
        @(negedge clk);
        pt_q[0] = P1;
        run_stream(K_NIST, IV_NIST, 1, 0, 0, 1'b0, -1);
        check("after_reset_c1", ct_q[0], C1);

        for (int t = 0; t < 8; t++) begin
            n  = int'($urandom_range(4, 1));
            si = int'($urandom_range(6, 0));
            so = int'($urandom_range(6, 0));
            for (int b = 0; b < 4; b++) pt_q[b] = rand128();
            run_stream(rand128(), rand128(), n, si, so, 1'($urandom_range(1, 0)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
